// File: rtl/ir_tx.sv
// NEC infrared transmitter: 16-bit code in, full frame plus repeat frames out.
// Define IR_TX_CARRIER_EN to modulate marks with the ~38 kHz carrier.
module ir_tx #(
  parameter int UNIT_CYC    = 15188,
  parameter int CARRIER_DIV = 711,
  parameter int CARRIER_HI  = 237
) (
  input  logic        clk27,
  input  logic        reset,
  input  logic [15:0] tx_code,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic        hold,
  output logic        ir_led,
  output logic        done,
  output logic [7:0]  rpt_cnt
);

  localparam int CW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;

  typedef enum logic [3:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    RPT_MARK,
    RPT_SPACE,
    RPT_STOP,
    GAP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0] cyc;
  logic [4:0]    unit;
  logic [4:0]    bit_idx;
  logic [7:0]    frame_unit;
  logic [15:0]   code;
  logic [31:0]   frame;
  logic [4:0]    dur_m1;
  logic          bit_one;
  logic          unit_end;
  logic          st_end;
  logic          gap_end;
  logic          accept;
  logic          rpt_start;
  logic          done_nx;
  logic          mark_nx;
  logic          led_nx;

  assign accept   = tx_valid & tx_ready;
  assign frame    = {~code[7:0], code[7:0], ~code[15:8], code[15:8]};
  assign bit_one  = frame[bit_idx];
  assign unit_end = (cyc == CW'(UNIT_CYC - 1));
  assign st_end   = unit_end && (unit == dur_m1);
  assign gap_end  = unit_end && (frame_unit == 8'd191);

  assign mark_nx = state_nx inside
    {LEAD_MARK, BIT_MARK, STOP_MARK, RPT_MARK, RPT_STOP};

  always_comb begin
    dur_m1 = 5'd0;
    unique case (state)
      LEAD_MARK:  dur_m1 = 5'd15;
      LEAD_SPACE: dur_m1 = 5'd7;
      BIT_SPACE:  dur_m1 = bit_one ? 5'd2 : 5'd0;
      RPT_MARK:   dur_m1 = 5'd15;
      RPT_SPACE:  dur_m1 = 5'd3;
      default:    dur_m1 = 5'd0;
    endcase
  end

  always_comb begin
    state_nx  = state;
    done_nx   = 1'b0;
    rpt_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = LEAD_MARK;
      end
      LEAD_MARK: begin
        if (st_end) state_nx = LEAD_SPACE;
      end
      LEAD_SPACE: begin
        if (st_end) state_nx = BIT_MARK;
      end
      BIT_MARK: begin
        if (st_end) state_nx = BIT_SPACE;
      end
      BIT_SPACE: begin
        if (st_end) begin
          state_nx = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
        end
      end
      STOP_MARK: begin
        if (st_end) state_nx = GAP;
      end
      RPT_MARK: begin
        if (st_end) state_nx = RPT_SPACE;
      end
      RPT_SPACE: begin
        if (st_end) state_nx = RPT_STOP;
      end
      RPT_STOP: begin
        if (st_end) state_nx = GAP;
      end
      GAP: begin
        if (gap_end) begin
          if (hold) begin
            state_nx  = RPT_MARK;
            rpt_start = 1'b1;
          end else begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef IR_TX_CARRIER_EN
  localparam int KW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  logic [KW-1:0] car;
  logic [KW-1:0] car_nx;

  // Every mark is a fresh state entry, so the carrier phase restarts there.
  always_comb begin
    car_nx = car + KW'(1);
    if (state_nx != state) begin
      car_nx = '0;
    end else if (car == KW'(CARRIER_DIV - 1)) begin
      car_nx = '0;
    end
  end

  assign led_nx = mark_nx && (car_nx < KW'(CARRIER_HI));

  always_ff @(posedge clk27) begin
    if (reset) begin
      car <= '0;
    end else begin
      car <= car_nx;
    end
  end
`else
  logic unused_carrier_cfg;

  assign unused_carrier_cfg = ^{CARRIER_DIV[0], CARRIER_HI[0]};
  assign led_nx = mark_nx;
`endif

  always_ff @(posedge clk27) begin
    if (reset) begin
      state      <= IDLE;
      cyc        <= '0;
      unit       <= '0;
      bit_idx    <= '0;
      frame_unit <= '0;
      code       <= '0;
      rpt_cnt    <= '0;
      tx_ready   <= 1'b1;
      ir_led     <= 1'b0;
      done       <= 1'b0;
    end else begin
      state    <= state_nx;
      tx_ready <= (state_nx == IDLE);
      ir_led   <= led_nx;
      done     <= done_nx;

      if (state_nx != state) begin
        cyc  <= '0;
        unit <= '0;
      end else if (state != IDLE) begin
        if (unit_end) begin
          cyc  <= '0;
          unit <= unit + 5'd1;
        end else begin
          cyc <= cyc + CW'(1);
        end
      end

      if (accept) begin
        bit_idx <= '0;
      end else if (state == BIT_SPACE && st_end) begin
        bit_idx <= bit_idx + 5'd1;
      end

      // Frame timer spans the whole 192-unit period, gap included.
      if (accept || rpt_start || state_nx == IDLE) begin
        frame_unit <= '0;
      end else if (unit_end) begin
        frame_unit <= frame_unit + 8'd1;
      end

      if (accept) begin
        code <= tx_code;
      end

      if (accept) begin
        rpt_cnt <= '0;
      end else if (rpt_start && rpt_cnt != 8'hFF) begin
        rpt_cnt <= rpt_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ir_tx.sv
// Directed bench for ir_tx with UNIT_CYC=8, CARRIER_DIV=6, CARRIER_HI=2.
// A second instance with UNIT_CYC=1 covers repeat-count saturation.
module tb_ir_tx;

  localparam int U  = 8;
  localparam int FR = 192 * U;

  logic        clk27 = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] tx_code = '0;
  logic        tx_valid = 1'b0;
  logic        hold = 1'b0;
  logic        tx_ready;
  logic        ir_led;
  logic        done;
  logic [7:0]  rpt_cnt;

  logic [15:0] s_code = '0;
  logic        s_valid = 1'b0;
  logic        s_hold = 1'b0;
  logic        s_ready;
  logic        s_led;
  logic        s_done;
  logic [7:0]  s_cnt;

  int errors = 0;
  int checks = 0;
  int unsigned ncyc = 0;

  logic wave [0:FR-1];
  logic expw [0:FR-1];
  int ep;
  int p;
  int first_bad;
  int early;

  ir_tx #(.UNIT_CYC(U), .CARRIER_DIV(6), .CARRIER_HI(2)) dut (
    .clk27(clk27),
    .reset(reset),
    .tx_code(tx_code),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .hold(hold),
    .ir_led(ir_led),
    .done(done),
    .rpt_cnt(rpt_cnt)
  );

  ir_tx #(.UNIT_CYC(1), .CARRIER_DIV(6), .CARRIER_HI(2)) u_sat (
    .clk27(clk27),
    .reset(reset),
    .tx_code(s_code),
    .tx_valid(s_valid),
    .tx_ready(s_ready),
    .hold(s_hold),
    .ir_led(s_led),
    .done(s_done),
    .rpt_cnt(s_cnt)
  );

  always #5 clk27 = ~clk27;

  always @(posedge clk27) ncyc <= ncyc + 1;

  task automatic step();
    @(posedge clk27);
    #1;
  endtask

  task automatic put(input int len, input bit mark);
    for (int i = 0; i < len; i++) begin
`ifdef IR_TX_CARRIER_EN
      expw[ep] = mark && ((i % 6) < 2);
`else
      expw[ep] = mark;
`endif
      ep++;
    end
  endtask

  task automatic build_full(input logic [15:0] c);
    logic [31:0] d;
    d = {~c[7:0], c[7:0], ~c[15:8], c[15:8]};
    ep = 0;
    put(16 * U, 1'b1);
    put(8 * U, 1'b0);
    for (int i = 0; i < 32; i++) begin
      put(U, 1'b1);
      put(d[i] ? 3 * U : U, 1'b0);
    end
    put(U, 1'b1);
    put(FR - ep, 1'b0);
  endtask

  task automatic build_rpt();
    ep = 0;
    put(16 * U, 1'b1);
    put(4 * U, 1'b0);
    put(U, 1'b1);
    put(FR - ep, 1'b0);
  endtask

  function automatic int wave_diff();
    int n;
    n = 0;
    first_bad = -1;
    for (int i = 0; i < FR; i++) begin
      if (wave[i] !== expw[i]) begin
        if (first_bad < 0) first_bad = i;
        n++;
      end
    end
    return n;
  endfunction

  function automatic int runl(input logic v);
    int n;
    n = 0;
    while (p < FR && wave[p] === v) begin
      n++;
      p++;
    end
    return n;
  endfunction

  function automatic int bit_start(input logic [15:0] c, input int b);
    logic [31:0] d;
    int s;
    d = {~c[7:0], c[7:0], ~c[15:8], c[15:8]};
    s = 24 * U;
    for (int j = 0; j < b; j++) s += d[j] ? 4 * U : 2 * U;
    return s;
  endfunction

  task automatic rec(input bit scramble, input int hold_off_at);
    early = 0;
    for (int k = 0; k < FR; k++) begin
      wave[k] = ir_led;
      if (done || tx_ready) early++;
      if (k == hold_off_at) hold = 1'b0;
      if (scramble) tx_code = 16'($urandom);
      step();
    end
  endtask

  task automatic accept(input logic [15:0] c);
    tx_code  = c;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({tx_ready, ir_led, done, rpt_cnt} !== 11'b100_0000_0000) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b",
        {tx_ready, ir_led, done, rpt_cnt}, 11'b100_0000_0000);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({tx_ready, ir_led, done, s_ready, s_cnt} !== 12'b100_1_0000_0000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected %b",
        {tx_ready, ir_led, done, s_ready, s_cnt}, 12'b100_1_0000_0000);
    end
  endtask

  task automatic test_frame();
    int n;
    int bad;
    logic [31:0] data;
    hold = 1'b0;
    accept(16'h20DF);
    checks++;
    if (tx_ready !== 1'b0 || ir_led !== 1'b1) begin
      errors++;
      $display("FAIL accept_latency: got ready=%b led=%b expected 0 1",
        tx_ready, ir_led);
    end
    rec(1'b0, -1);
    build_full(16'h20DF);
    n = wave_diff();
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL frame_wave: got %0d bad cycles (first %0d) expected 0",
        n, first_bad);
    end
`ifndef IR_TX_CARRIER_EN
    p = 0;
    n = runl(1'b1);
    checks++;
    if (n !== 128) begin
      errors++;
      $display("FAIL lead_mark: got %0d expected 128", n);
    end
    n = runl(1'b0);
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL lead_space: got %0d expected 64", n);
    end
    bad = 0;
    data = '0;
    for (int i = 0; i < 32; i++) begin
      n = runl(1'b1);
      if (n != 8) bad++;
      n = runl(1'b0);
      data[i] = (n > 16);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bit_marks: got %0d bad marks expected 0", bad);
    end
    checks++;
    if (data !== 32'h20DF_DF20) begin
      errors++;
      $display("FAIL decoded_bytes: got %h expected %h", data, 32'h20DF_DF20);
    end
    n = runl(1'b1);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL stop_mark: got %0d expected 8", n);
    end
`endif
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL frame_busy: got %0d ready/done cycles expected 0", early);
    end
    checks++;
    if ({done, tx_ready, rpt_cnt} !== 10'b11_0000_0000) begin
      errors++;
      $display("FAIL done_at_1536: got %b expected %b",
        {done, tx_ready, rpt_cnt}, 10'b11_0000_0000);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: got %b expected 0", done);
    end
  endtask

  task automatic test_carrier();
    int n;
    hold = 1'b0;
    accept(16'h20DF);
    rec(1'b0, -1);
    build_full(16'h20DF);
    n = wave_diff();
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL carrier_wave: got %0d bad cycles (first %0d) expected 0",
        n, first_bad);
    end
    n = 0;
    for (int i = 0; i < 128; i++) n += (wave[i] === 1'b1) ? 1 : 0;
    checks++;
    if (n !== 44 || wave[126] !== 1'b1 || wave[127] !== 1'b1) begin
      errors++;
      $display("FAIL carrier_lead: got %0d highs tail %b%b expected 44 11",
        n, wave[126], wave[127]);
    end
    checks++;
    if ({wave[192], wave[193], wave[194], wave[195],
         wave[196], wave[197], wave[198], wave[199]} !== 8'b1100_0011) begin
      errors++;
      $display("FAIL carrier_restart: got %b expected 11000011",
        {wave[192], wave[193], wave[194], wave[195],
         wave[196], wave[197], wave[198], wave[199]});
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL carrier_done: got %b expected 1", done);
    end
    step();
  endtask

  task automatic test_repeat();
    int n;
    hold = 1'b1;
    accept(16'h0000);
    rec(1'b0, -1);
    build_full(16'h0000);
    n = wave_diff();
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL rpt_first_frame: got %0d bad cycles (first %0d) expected 0",
        n, first_bad);
    end
    checks++;
    if ({done, ir_led, rpt_cnt} !== 10'b01_0000_0001) begin
      errors++;
      $display("FAIL rpt1_start: got %b expected %b",
        {done, ir_led, rpt_cnt}, 10'b01_0000_0001);
    end
    rec(1'b0, -1);
    build_rpt();
    n = wave_diff();
    checks++;
    if (n !== 0 || early !== 0) begin
      errors++;
      $display("FAIL rpt1_wave: got %0d bad (first %0d) %0d busy expected 0 0",
        n, first_bad, early);
    end
    checks++;
    if ({done, ir_led, rpt_cnt} !== 10'b01_0000_0010) begin
      errors++;
      $display("FAIL rpt2_start: got %b expected %b",
        {done, ir_led, rpt_cnt}, 10'b01_0000_0010);
    end
    rec(1'b0, 700);
    n = wave_diff();
    checks++;
    if (n !== 0 || early !== 0) begin
      errors++;
      $display("FAIL rpt2_wave: got %0d bad (first %0d) %0d busy expected 0 0",
        n, first_bad, early);
    end
    checks++;
    if ({done, tx_ready, ir_led, rpt_cnt} !== 11'b110_0000_0010) begin
      errors++;
      $display("FAIL rpt_done: got %b expected %b",
        {done, tx_ready, ir_led, rpt_cnt}, 11'b110_0000_0010);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    int unsigned t1;
    int unsigned t2;
    hold = 1'b0;
    tx_code  = 16'h5AC3;
    tx_valid = 1'b1;
    step();
    t1 = ncyc;
    checks++;
    if (rpt_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rpt_cnt_clear: got %0d expected 0", rpt_cnt);
    end
    rec(1'b1, -1);
    build_full(16'h5AC3);
    n = wave_diff();
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL b2b_frame_a: got %0d bad cycles (first %0d) expected 0",
        n, first_bad);
    end
    checks++;
    if (done !== 1'b1 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done_a: got done=%b ready=%b expected 1 1",
        done, tx_ready);
    end
    tx_code = 16'h1E87;
    step();
    t2 = ncyc;
    checks++;
    if (t2 - t1 !== 1537) begin
      errors++;
      $display("FAIL accept_spacing: got %0d expected 1537", t2 - t1);
    end
    rec(1'b1, -1);
    build_full(16'h1E87);
    n = wave_diff();
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL b2b_frame_b: got %0d bad cycles (first %0d) expected 0",
        n, first_bad);
    end
    tx_valid = 1'b0;
    step();
    checks++;
    if (tx_ready !== 1'b1 || ir_led !== 1'b0) begin
      errors++;
      $display("FAIL b2b_release: got ready=%b led=%b expected 1 0",
        tx_ready, ir_led);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int bs;
    hold = 1'b0;
    bs = bit_start(16'hA53C, 10);
    accept(16'hA53C);
    repeat (bs) step();
    checks++;
    if (ir_led !== 1'b1) begin
      errors++;
      $display("FAIL bit10_mark: got %b expected 1", ir_led);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({ir_led, tx_ready, done} !== 3'b010) begin
      errors++;
      $display("FAIL mid_reset: got %b expected 010",
        {ir_led, tx_ready, done});
    end
    n = 0;
    repeat (20) begin
      step();
      if (done !== 1'b0 || ir_led !== 1'b0 || tx_ready !== 1'b1) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL after_reset_quiet: got %0d bad cycles expected 0", n);
    end
    accept(16'h7E81);
    rec(1'b0, -1);
    build_full(16'h7E81);
    n = wave_diff();
    checks++;
    if (n !== 0 || done !== 1'b1) begin
      errors++;
      $display("FAIL fresh_frame: got %0d bad (first %0d) done=%b expected 0 1",
        n, first_bad, done);
    end
    step();
  endtask

  task automatic test_saturate();
    int bad;
    int dn;
    s_code  = 16'h1234;
    s_hold  = 1'b1;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    bad = 0;
    dn  = 0;
    for (int f = 1; f <= 258; f++) begin
      repeat (192) begin
        if (s_done) dn++;
        step();
      end
      if (s_cnt !== 8'((f < 255) ? f : 255)) bad++;
    end
    checks++;
    if (bad !== 0 || dn !== 0) begin
      errors++;
      $display("FAIL sat_progress: got %0d bad counts %0d dones expected 0 0",
        bad, dn);
    end
    checks++;
    if (s_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_value: got %0d expected 255", s_cnt);
    end
    s_hold = 1'b0;
    repeat (192) step();
    checks++;
    if ({s_done, s_ready, s_cnt} !== 10'b11_1111_1111) begin
      errors++;
      $display("FAIL sat_done: got %b expected %b",
        {s_done, s_ready, s_cnt}, 10'b11_1111_1111);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
`ifdef IR_TX_CARRIER_EN
    test_carrier();
`endif
    test_repeat();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
